// File: rtl/ca_pkg.sv
// Shared constants and state type for the cellular-automaton board engine.
// Halt reasons, edge modes and the Conway rule masks live here.
package ca_pkg;

   localparam logic [1:0] HALT_NONE   = 2'd0;
   localparam logic [1:0] HALT_COUNT  = 2'd1;
   localparam logic [1:0] HALT_STOP   = 2'd2;
   localparam logic [1:0] HALT_STABLE = 2'd3;

   localparam logic EDGE_DEAD = 1'b0;
   localparam logic EDGE_WRAP = 1'b1;

   // Bit n of a mask applies to a cell with n live neighbours.
   localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
   localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

endpackage

// File: rtl/ca_cell_rule.sv
// Next-state rule for one cell: count live neighbours, then select the
// birth or survive mask bit depending on the current cell state.
module ca_cell_rule (
   input  logic       cur,
   input  logic [7:0] nbr,
   input  logic [8:0] birth_mask,
   input  logic [8:0] survive_mask,
   output logic       next
);

   logic [3:0] live_count;

   always_comb begin
      live_count = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         live_count = live_count + {3'b000, nbr[i]};
      end
      next = cur ? survive_mask[live_count] : birth_mask[live_count];
   end

endmodule

// File: rtl/ca_board_engine.sv
// Cellular-automaton board register with a one-generation-per-clock run
// controller, dead/toroidal edges, programmable rules and halt detection.
module ca_board_engine
   import ca_pkg::*;
#(
   parameter int BOARD_WIDTH  = 32,
   parameter int BOARD_HEIGHT = 32,
   parameter int STEP_WIDTH   = 16,
   parameter int GEN_WIDTH    = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              load_en,
   input  logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] new_board_state,
   input  logic                              start,
   input  logic [STEP_WIDTH-1:0]             step_count,
   input  logic                              stop,
   input  logic                              edge_mode,
   input  logic [8:0]                        birth_mask,
   input  logic [8:0]                        survive_mask,
   output logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] board_state,
   output logic                              busy,
   output logic                              done,
   output logic [GEN_WIDTH-1:0]              generation,
   output logic                              stable,
   output logic                              extinct,
   output logic [1:0]                        halt_reason
);

   localparam int CELLS = BOARD_WIDTH * BOARD_HEIGHT;

   state_t                state;
   logic [CELLS-1:0]      board;
   logic [CELLS-1:0]      next_board;
   logic [STEP_WIDTH-1:0] remaining;
   logic                  edge_cfg;
   logic [8:0]            birth_cfg;
   logic [8:0]            survive_cfg;
   logic [GEN_WIDTH-1:0]  gen_count;
   logic                  done_r;
   logic                  stable_r;
   logic [1:0]            halt_r;

   // Each cell sees its 8 neighbours; off-board neighbours are masked to 0
   // unless the latched edge mode wraps the board into a torus.
   for (genvar y = 0; y < BOARD_HEIGHT; y++) begin : g_row
      for (genvar x = 0; x < BOARD_WIDTH; x++) begin : g_col
         localparam int XL   = (x == 0) ? BOARD_WIDTH - 1 : x - 1;
         localparam int XR   = (x == BOARD_WIDTH - 1) ? 0 : x + 1;
         localparam int YU   = (y == 0) ? BOARD_HEIGHT - 1 : y - 1;
         localparam int YD   = (y == BOARD_HEIGHT - 1) ? 0 : y + 1;
         localparam bit ON_L = (x == 0);
         localparam bit ON_R = (x == BOARD_WIDTH - 1);
         localparam bit ON_U = (y == 0);
         localparam bit ON_D = (y == BOARD_HEIGHT - 1);

         logic       keep_l;
         logic       keep_r;
         logic       keep_u;
         logic       keep_d;
         logic [7:0] nbr;

         assign keep_l = edge_cfg | ~ON_L;
         assign keep_r = edge_cfg | ~ON_R;
         assign keep_u = edge_cfg | ~ON_U;
         assign keep_d = edge_cfg | ~ON_D;

         assign nbr = {
            board[YD*BOARD_WIDTH + XR] & keep_d & keep_r,
            board[YD*BOARD_WIDTH + x]  & keep_d,
            board[YD*BOARD_WIDTH + XL] & keep_d & keep_l,
            board[y*BOARD_WIDTH + XR]  & keep_r,
            board[y*BOARD_WIDTH + XL]  & keep_l,
            board[YU*BOARD_WIDTH + XR] & keep_u & keep_r,
            board[YU*BOARD_WIDTH + x]  & keep_u,
            board[YU*BOARD_WIDTH + XL] & keep_u & keep_l
         };

         ca_cell_rule u_cell (
            .cur          (board[y*BOARD_WIDTH + x]),
            .nbr          (nbr),
            .birth_mask   (birth_cfg),
            .survive_mask (survive_cfg),
            .next         (next_board[y*BOARD_WIDTH + x])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         board       <= '0;
         gen_count   <= '0;
         remaining   <= '0;
         edge_cfg    <= EDGE_DEAD;
         birth_cfg   <= CONWAY_BIRTH;
         survive_cfg <= CONWAY_SURVIVE;
         done_r      <= 1'b0;
         stable_r    <= 1'b0;
         halt_r      <= HALT_NONE;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_en) begin
                  board     <= new_board_state;
                  gen_count <= '0;
                  stable_r  <= 1'b0;
                  halt_r    <= HALT_NONE;
               end else if (start) begin
                  remaining   <= step_count;
                  edge_cfg    <= edge_mode;
                  birth_cfg   <= birth_mask;
                  survive_cfg <= survive_mask;
                  state       <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state    <= ST_IDLE;
                  done_r   <= 1'b1;
                  stable_r <= 1'b0;
                  halt_r   <= HALT_STOP;
               end else if (next_board == board) begin
                  state    <= ST_IDLE;
                  done_r   <= 1'b1;
                  stable_r <= 1'b1;
                  halt_r   <= HALT_STABLE;
               end else begin
                  board     <= next_board;
                  gen_count <= gen_count + 1'b1;
                  // remaining==0 means unbounded and is never decremented.
                  if (remaining == STEP_WIDTH'(1)) begin
                     state    <= ST_IDLE;
                     done_r   <= 1'b1;
                     stable_r <= 1'b0;
                     halt_r   <= HALT_COUNT;
                  end else if (remaining != '0) begin
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign board_state = board;
   assign busy        = (state == ST_RUN);
   assign done        = done_r;
   assign generation  = gen_count;
   assign stable      = stable_r;
   assign halt_reason = halt_r;
   assign extinct     = ~|board;

endmodule
